// File: rtl/ref_block_reader_if.sv
// Handshake/bus bundle between the reference block reader, the DRAM read port and the SW engine.
// The master modport is the reader; the slave modport is its environment.
interface ref_block_reader_if #(
    parameter int REF_LENGTH = 128,
    parameter int ADDR_WIDTH = 25
);
    logic [ADDR_WIDTH-1:0]   ref_addr_in;
    logic [ADDR_WIDTH-1:0]   ref_length_in;
    logic                    ref_info_valid_in;
    logic                    busy_out;
    logic [ADDR_WIDTH-1:0]   dram_cmd_addr_out;
    logic                    dram_cmd_valid_out;
    logic                    dram_cmd_rdy_in;
    logic [2*REF_LENGTH-1:0] dram_rd_data_in;
    logic                    dram_rd_valid_in;
    logic [2*REF_LENGTH-1:0] ref_seq_block_out;
    logic                    ref_seq_block_valid_out;
    logic                    ref_seq_block_rdy_in;
    logic                    err_out;

    modport master (
        input  ref_addr_in, ref_length_in, ref_info_valid_in,
        input  dram_cmd_rdy_in, dram_rd_data_in, dram_rd_valid_in,
        input  ref_seq_block_rdy_in,
        output busy_out, dram_cmd_addr_out, dram_cmd_valid_out,
        output ref_seq_block_out, ref_seq_block_valid_out, err_out
    );

    modport slave (
        output ref_addr_in, ref_length_in, ref_info_valid_in,
        output dram_cmd_rdy_in, dram_rd_data_in, dram_rd_valid_in,
        output ref_seq_block_rdy_in,
        input  busy_out, dram_cmd_addr_out, dram_cmd_valid_out,
        input  ref_seq_block_out, ref_seq_block_valid_out, err_out
    );
endinterface

// File: rtl/ref_block_reader.sv
// Issues one DRAM read per reference block and streams the in-order returns to the SW engine.
// Reads are credit-limited so the return FIFO can always absorb every outstanding return.
module ref_block_reader #(
    parameter int REF_LENGTH = 128,
    parameter int ADDR_WIDTH = 25,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    ref_block_reader_if.master bus
);
    localparam int BW = 2 * REF_LENGTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    logic                  cmd_vld_q, cmd_vld_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic                  err_q;
    logic [BW-1:0]         mem_q [FIFO_DEPTH];
    logic [CW:0]           credit_sum;

    logic cmd_fire, ret_ok, ret_bad, pop, fifo_vld;

    assign cmd_fire = cmd_vld_q & bus.dram_cmd_rdy_in;
    assign ret_ok   = bus.dram_rd_valid_in & (outst_q != '0);
    assign ret_bad  = bus.dram_rd_valid_in & (outst_q == '0);
    assign fifo_vld = (cnt_q != '0);
    assign pop      = fifo_vld & bus.ref_seq_block_rdy_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        outst_d    = outst_q + CW'(cmd_fire) - CW'(ret_ok);
        cnt_d      = cnt_q + CW'(ret_ok) - CW'(pop);
        case (state_q)
            IDLE: begin
                if (bus.ref_info_valid_in && (bus.ref_length_in != '0)) begin
                    addr_d  = bus.ref_addr_in;
                    rem_d   = bus.ref_length_in;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_fire) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - ADDR_WIDTH'(1);
                    if (rem_q == ADDR_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((outst_q == '0) && !fifo_vld) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Credits only grow while a command is stalled, so a raised valid stays up until rdy.
        credit_sum = {1'b0, outst_d} + {1'b0, cnt_d};
        cmd_vld_d  = (state_d == ISSUE) && (credit_sum < (CW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            rem_q     <= '0;
            cmd_vld_q <= 1'b0;
            outst_q   <= '0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            cmd_vld_q <= cmd_vld_d;
            outst_q   <= outst_d;
            cnt_q     <= cnt_d;
            if (ret_ok) wptr_q <= wptr_q + PW'(1);
            if (pop)    rptr_q <= rptr_q + PW'(1);
            if (ret_bad) err_q <= 1'b1;
        end
    end

    // Storage needs no reset: the read port is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (ret_ok) mem_q[wptr_q] <= bus.dram_rd_data_in;
    end

    assign bus.busy_out                = (state_q != IDLE);
    assign bus.dram_cmd_addr_out       = addr_q;
    assign bus.dram_cmd_valid_out      = cmd_vld_q;
    assign bus.ref_seq_block_valid_out = fifo_vld;
    assign bus.ref_seq_block_out       = fifo_vld ? mem_q[rptr_q] : '0;
    assign bus.err_out                 = err_q;
endmodule

// File: tb/tb_ref_block_reader.sv
// Scoreboard bench: expected cmd addresses and blocks are queued at request time and
// retired as the DUT hands them out; a latency-programmable DRAM model answers reads.
module tb_ref_block_reader;
    localparam int RL = 128;
    localparam int AW = 25;
    localparam int BW = 2 * RL;
    localparam int D  = 8;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
    } pend_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ref_block_reader_if #(.REF_LENGTH(RL), .ADDR_WIDTH(AW)) bus ();

    ref_block_reader #(.REF_LENGTH(RL), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] exp_cmd [$];
    logic [BW-1:0] exp_blk [$];
    pend_t         pend [$];
    int            cmd_cyc [$];

    int cyc = 0, ncmd = 0, nblk = 0, outst = 0, maxout = 0;
    int lat = 4;
    int cmd_mode = 0;
    bit blk_rdy_en = 1'b1;
    bit stall_q = 1'b0;
    logic [AW-1:0] stall_addr;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] blk_data(input logic [AW-1:0] a);
        logic [BW-1:0] d;
        for (int k = 0; k < BW/32; k++) d[k*32 +: 32] = {7'(k), a} ^ 32'h9E37_79B9;
        return d;
    endfunction

    // DRAM model, ready generators and output monitor; all act on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            case (cmd_mode)
                0:       bus.dram_cmd_rdy_in = 1'b1;
                1:       bus.dram_cmd_rdy_in = cyc[0];
                default: bus.dram_cmd_rdy_in = 1'b0;
            endcase
            bus.ref_seq_block_rdy_in = blk_rdy_en;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.dram_rd_valid_in = 1'b1;
                bus.dram_rd_data_in  = blk_data(pend[0].a);
                void'(pend.pop_front());
                if (outst > 0) outst--;
            end else begin
                bus.dram_rd_valid_in = 1'b0;
                bus.dram_rd_data_in  = '0;
            end
            if (!rst) begin
                outst   = 0;
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    chk("cmd_hold_valid", bus.dram_cmd_valid_out, 1);
                    chk("cmd_hold_addr", bus.dram_cmd_addr_out, stall_addr);
                end
                stall_q    = bus.dram_cmd_valid_out && !bus.dram_cmd_rdy_in;
                stall_addr = bus.dram_cmd_addr_out;
                if (bus.dram_cmd_valid_out && bus.dram_cmd_rdy_in) begin
                    if (exp_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
                    else chk("cmd_addr", bus.dram_cmd_addr_out, exp_cmd.pop_front());
                    pend.push_back('{a: bus.dram_cmd_addr_out, due: cyc + lat});
                    cmd_cyc.push_back(cyc);
                    ncmd++;
                    outst++;
                    if (outst > maxout) maxout = outst;
                end
                if (bus.ref_seq_block_valid_out && bus.ref_seq_block_rdy_in) begin
                    if (exp_blk.size() == 0) chk("blk_unexpected", 1, 0);
                    else chk("blk_data", bus.ref_seq_block_out, exp_blk.pop_front());
                    nblk++;
                end
            end
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] len, input bit expect_it);
        bus.ref_info_valid_in = 1'b1;
        bus.ref_addr_in       = a;
        bus.ref_length_in     = len;
        if (expect_it) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_cmd.push_back(a + AW'(i));
                exp_blk.push_back(blk_data(a + AW'(i)));
            end
        end
        @(posedge clk); #1;
        bus.ref_info_valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.busy_out || exp_blk.size() != 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, n < 2000, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, bus.busy_out, 0);
        chk({tag, "_cmdv"}, bus.dram_cmd_valid_out, 0);
        chk({tag, "_cmda"}, bus.dram_cmd_addr_out, 0);
        chk({tag, "_blkv"}, bus.ref_seq_block_valid_out, 0);
        chk({tag, "_blk"}, bus.ref_seq_block_out, 0);
        chk({tag, "_err"}, bus.err_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, bb, n;
        rst = 1'b0;
        bus.ref_info_valid_in = 1'b0;
        bus.ref_addr_in       = '0;
        bus.ref_length_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: short request, back-to-back commands
        b = cmd_cyc.size(); bb = nblk;
        send(25'h100, 3, 1);
        wait_idle("t1_done");
        chk("t1_consec1", cmd_cyc[b+1] - cmd_cyc[b], 1);
        chk("t1_consec2", cmd_cyc[b+2] - cmd_cyc[b], 2);
        chk("t1_nblk", nblk - bb, 3);
        chk("t1_busy", bus.busy_out, 0);

        // 2: stalled consumer caps reads at the FIFO depth
        blk_rdy_en = 1'b0;
        b = ncmd; bb = nblk;
        send(25'h200, 20, 1);
        repeat (30) @(posedge clk);
        #1;
        chk("t2_ncmd_cap", ncmd - b, D);
        chk("t2_cmdv_low", bus.dram_cmd_valid_out, 0);
        chk("t2_blkv", bus.ref_seq_block_valid_out, 1);
        blk_rdy_en = 1'b1;
        wait_idle("t2_done");
        chk("t2_ncmd", ncmd - b, 20);
        chk("t2_nblk", nblk - bb, 20);

        // 3: address wrap
        bb = nblk;
        send(25'h1FF_FFFE, 4, 1);
        wait_idle("t3_done");
        chk("t3_nblk", nblk - bb, 4);

        // 4: zero length, then a request while busy is ignored
        b = ncmd;
        send(25'h300, 0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("t4_len0_busy", bus.busy_out, 0);
            chk("t4_len0_cmdv", bus.dram_cmd_valid_out, 0);
            @(posedge clk); #1;
        end
        chk("t4_len0_ncmd", ncmd - b, 0);
        bb = nblk;
        send(25'h400, 5, 1);
        send(25'h900, 3, 0);
        send(25'h900, 3, 0);
        wait_idle("t4_done");
        chk("t4_nblk", nblk - bb, 5);
        chk("t4_cmdq_empty", exp_cmd.size(), 0);

        // 5: toggling cmd ready, simultaneous accept and return
        cmd_mode = 1;
        lat = 1;
        maxout = 0;
        bb = nblk;
        send(25'h500, 12, 1);
        wait_idle("t5a_done");
        lat = 9;
        send(25'h600, 16, 1);
        blk_rdy_en = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        blk_rdy_en = 1'b1;
        wait_idle("t5b_done");
        chk("t5_nblk", nblk - bb, 28);
        chk("t5_maxout_le_depth", maxout <= D, 1);
        chk("t5_err", bus.err_out, 0);

        // 6: reset with two reads in flight
        cmd_mode = 0;
        lat = 10;
        b = ncmd;
        send(25'h40, 4, 1);
        n = 0;
        while (ncmd - b < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_two_cmds", ncmd - b, 2);
        cmd_mode = 2;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        exp_cmd.delete();
        exp_blk.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cmd_mode = 0;
        n = 0;
        while (pend.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("t6_err", bus.err_out, 1);
        chk("t6_blkv", bus.ref_seq_block_valid_out, 0);
        chk("t6_busy", bus.busy_out, 0);
        lat = 4;
        bb = nblk;
        send(25'h60, 2, 1);
        wait_idle("t6_done");
        chk("t6_nblk", nblk - bb, 2);
        chk("t6_err_sticky", bus.err_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
